// File: rtl/eth_rx_ring_dma.sv
// Ethernet RX DMA writer that fills a ring of software-posted buffers: payload at base+8, length at base+0.
// Optional per-cause drop counters are built when ETH_RX_DROP_STATS_EN is defined.
module eth_rx_ring_dma #(
    parameter int axis_data_width_p = 64,
    parameter int num_bufs_p        = 4,
    parameter int addr_width_p      = 40,
    parameter int len_width_p       = 16,
    parameter int max_frame_bytes_p = 2048,
    parameter int max_credits_p     = 256
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               cmd_v_i,
    input  logic [1:0]                         cmd_i,
    input  logic [addr_width_p-1:0]            cmd_arg_i,
    input  logic [axis_data_width_p-1:0]       rx_axis_tdata_i,
    input  logic [axis_data_width_p/8-1:0]     rx_axis_tkeep_i,
    input  logic                               rx_axis_tvalid_i,
    output logic                               rx_axis_tready_o,
    input  logic                               rx_axis_tlast_i,
    input  logic                               rx_axis_tuser_i,
    output logic                               mem_cmd_v_o,
    output logic [addr_width_p-1:0]            mem_cmd_addr_o,
    output logic [axis_data_width_p-1:0]       mem_cmd_data_o,
    output logic [2:0]                         mem_cmd_size_o,
    input  logic                               mem_cmd_yumi_i,
    input  logic                               mem_resp_v_i,
    output logic [$clog2(num_bufs_p+1)-1:0]    filled_cnt_o,
    output logic [$clog2(num_bufs_p+1)-1:0]    posted_cnt_o,
    output logic                               busy_o
`ifdef ETH_RX_DROP_STATS_EN
    ,
    output logic [15:0]                        drop_nobuf_o,
    output logic [15:0]                        drop_bad_o,
    output logic [15:0]                        drop_long_o
`endif
);

    localparam int KW  = axis_data_width_p / 8;
    localparam int PW  = (num_bufs_p > 1) ? $clog2(num_bufs_p) : 1;
    localparam int CW  = $clog2(num_bufs_p + 1);
    localparam int CRW = $clog2(max_credits_p + 1);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(KW));

    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_DROP, S_LEN, S_SYNC} state_e;

    state_e                  state_q, state_d;
    logic [addr_width_p-1:0] base_q [num_bufs_p];
    logic [PW-1:0]           post_ptr_q, post_ptr_d, fill_ptr_q, fill_ptr_d, ack_ptr_q, ack_ptr_d;
    logic [CW-1:0]           posted_q, posted_d, filled_q, filled_d;
    logic [len_width_p-1:0]  count_q, count_d;
    logic [addr_width_p-1:0] offset_q, offset_d;
    logic [CRW-1:0]          credits_q, credits_d;

    logic                    post_ok, ack_ok, fill_done, wr_sent, credit_full, oversize;
    logic [CW:0]             occupancy;
    logic [len_width_p:0]    next_count;

    function automatic logic [len_width_p-1:0] popcount(input logic [KW-1:0] k);
        logic [len_width_p-1:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + len_width_p'(k[i]);
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(num_bufs_p - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ring bookkeeping: POST and ACK share one command port; a fill completion may coincide with either.
    assign occupancy  = {1'b0, posted_q} + {1'b0, filled_q};
    assign post_ok    = cmd_v_i && (cmd_i == 2'b01) && (occupancy < (CW+1)'(num_bufs_p));
    assign ack_ok     = cmd_v_i && (cmd_i == 2'b10) && (filled_q != '0);
    assign post_ptr_d = post_ok   ? ptr_inc(post_ptr_q) : post_ptr_q;
    assign fill_ptr_d = fill_done ? ptr_inc(fill_ptr_q) : fill_ptr_q;
    assign ack_ptr_d  = ack_ok    ? ptr_inc(ack_ptr_q)  : ack_ptr_q;
    assign posted_d   = posted_q + CW'(post_ok) - CW'(fill_done);
    assign filled_d   = filled_q + CW'(fill_done) - CW'(ack_ok);

    assign credit_full = (credits_q == CRW'(max_credits_p));
    assign next_count  = {1'b0, count_q} + {1'b0, popcount(rx_axis_tkeep_i)};
    assign oversize    = next_count > (len_width_p+1)'(max_frame_bytes_p);

    always_comb begin
        credits_d = credits_q;
        if (wr_sent && !(mem_resp_v_i && credits_q != '0)) credits_d = credits_q + CRW'(1);
        else if (!wr_sent && mem_resp_v_i && credits_q != '0) credits_d = credits_q - CRW'(1);
    end

    // A write transfers when mem_cmd_v_o && mem_cmd_yumi_i; a beat transfers when
    // rx_axis_tvalid_i && rx_axis_tready_o. Payload beats are accepted exactly when their write is.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        offset_d         = offset_q;
        mem_cmd_v_o      = 1'b0;
        mem_cmd_addr_o   = '0;
        mem_cmd_data_o   = '0;
        mem_cmd_size_o   = '0;
        rx_axis_tready_o = 1'b0;
        wr_sent          = 1'b0;
        fill_done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_axis_tvalid_i) begin
                    count_d  = '0;
                    offset_d = base_q[fill_ptr_q] + addr_width_p'(8);
                    state_d  = (posted_q != '0) ? S_PAYLOAD : S_DROP;
                end
            end
            S_PAYLOAD: begin
                if (rx_axis_tvalid_i) begin
                    mem_cmd_v_o    = !credit_full;
                    mem_cmd_addr_o = offset_q;
                    mem_cmd_size_o = BEAT_SIZE;
                    mem_cmd_data_o = rx_axis_tdata_i;
                    if (rx_axis_tlast_i && rx_axis_tuser_i) begin
                        // Bad frame: swallow the last beat, leave the buffer posted for reuse.
                        rx_axis_tready_o = 1'b1;
                        state_d          = S_IDLE;
                    end else if (oversize) begin
                        mem_cmd_v_o = 1'b0;
                        state_d     = S_DROP;
                    end else begin
                        rx_axis_tready_o = mem_cmd_yumi_i && !credit_full;
                        if (rx_axis_tready_o) begin
                            wr_sent  = 1'b1;
                            count_d  = next_count[len_width_p-1:0];
                            offset_d = offset_q + addr_width_p'(KW);
                            if (rx_axis_tlast_i) state_d = S_LEN;
                        end
                    end
                end
            end
            S_DROP: begin
                rx_axis_tready_o = 1'b1;
                if (rx_axis_tvalid_i && rx_axis_tlast_i) state_d = S_IDLE;
            end
            S_LEN: begin
                mem_cmd_v_o    = !credit_full;
                mem_cmd_addr_o = base_q[fill_ptr_q];
                mem_cmd_size_o = 3'd3;
                mem_cmd_data_o = axis_data_width_p'(count_q);
                if (mem_cmd_v_o && mem_cmd_yumi_i) begin
                    wr_sent = 1'b1;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // The buffer is handed to software only after every write has been acknowledged.
                if (credits_q == '0) begin
                    fill_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            post_ptr_q <= '0;
            fill_ptr_q <= '0;
            ack_ptr_q  <= '0;
            posted_q   <= '0;
            filled_q   <= '0;
            count_q    <= '0;
            offset_q   <= '0;
            credits_q  <= '0;
        end else begin
            state_q    <= state_d;
            post_ptr_q <= post_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            ack_ptr_q  <= ack_ptr_d;
            posted_q   <= posted_d;
            filled_q   <= filled_d;
            count_q    <= count_d;
            offset_q   <= offset_d;
            credits_q  <= credits_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (post_ok) base_q[post_ptr_q] <= cmd_arg_i;
    end

    assign filled_cnt_o = filled_q;
    assign posted_cnt_o = posted_q;
    assign busy_o       = (state_q != S_IDLE);

`ifdef ETH_RX_DROP_STATS_EN
    logic [15:0] drop_nobuf_q, drop_bad_q, drop_long_q;
    logic        ev_nobuf, ev_bad, ev_long;

    assign ev_nobuf = (state_q == S_IDLE) && rx_axis_tvalid_i && (posted_q == '0);
    assign ev_bad   = (state_q == S_PAYLOAD) && rx_axis_tvalid_i && rx_axis_tlast_i && rx_axis_tuser_i;
    assign ev_long  = (state_q == S_PAYLOAD) && rx_axis_tvalid_i && oversize
                      && !(rx_axis_tlast_i && rx_axis_tuser_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_nobuf_q <= '0;
            drop_bad_q   <= '0;
            drop_long_q  <= '0;
        end else begin
            if (ev_nobuf && drop_nobuf_q != 16'hFFFF) drop_nobuf_q <= drop_nobuf_q + 16'd1;
            if (ev_bad   && drop_bad_q   != 16'hFFFF) drop_bad_q   <= drop_bad_q + 16'd1;
            if (ev_long  && drop_long_q  != 16'hFFFF) drop_long_q  <= drop_long_q + 16'd1;
        end
    end

    assign drop_nobuf_o = drop_nobuf_q;
    assign drop_bad_o   = drop_bad_q;
    assign drop_long_o  = drop_long_q;
`endif

endmodule

// File: tb/tb_eth_rx_ring_dma.sv
// Directed and randomized frames against a buffer-ring reference model of eth_rx_ring_dma.
// The memory side issues random yumi/response timing; written beats are compared to expected writes.
module tb_eth_rx_ring_dma;

    localparam int AXW  = 64;
    localparam int NB   = 4;
    localparam int AW   = 40;
    localparam int LW   = 16;
    localparam int MAXB = 40;
    localparam int MAXC = 3;
    localparam int CW   = $clog2(NB + 1);
    localparam int EW   = AW + AXW + 3;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            cmd_v_i;
    logic [1:0]      cmd_i;
    logic [AW-1:0]   cmd_arg_i;
    logic [AXW-1:0]  rx_axis_tdata_i;
    logic [AXW/8-1:0] rx_axis_tkeep_i;
    logic            rx_axis_tvalid_i;
    logic            rx_axis_tready_o;
    logic            rx_axis_tlast_i;
    logic            rx_axis_tuser_i;
    logic            mem_cmd_v_o;
    logic [AW-1:0]   mem_cmd_addr_o;
    logic [AXW-1:0]  mem_cmd_data_o;
    logic [2:0]      mem_cmd_size_o;
    logic            mem_cmd_yumi_i;
    logic            mem_resp_v_i;
    logic [CW-1:0]   filled_cnt_o;
    logic [CW-1:0]   posted_cnt_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [AW-1:0] posted_m[$];
    int  filled_m    = 0;
    int  outstanding = 0;
    int  max_out     = 0;
    bit  hold_yumi   = 1'b0;

    always #5 clk = ~clk;

    eth_rx_ring_dma #(
        .axis_data_width_p(AXW), .num_bufs_p(NB), .addr_width_p(AW),
        .len_width_p(LW), .max_frame_bytes_p(MAXB), .max_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_i(cmd_i), .cmd_arg_i(cmd_arg_i),
        .rx_axis_tdata_i(rx_axis_tdata_i), .rx_axis_tkeep_i(rx_axis_tkeep_i),
        .rx_axis_tvalid_i(rx_axis_tvalid_i), .rx_axis_tready_o(rx_axis_tready_o),
        .rx_axis_tlast_i(rx_axis_tlast_i), .rx_axis_tuser_i(rx_axis_tuser_i),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_addr_o(mem_cmd_addr_o),
        .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_size_o(mem_cmd_size_o),
        .mem_cmd_yumi_i(mem_cmd_yumi_i), .mem_resp_v_i(mem_resp_v_i),
        .filled_cnt_o(filled_cnt_o), .posted_cnt_o(posted_cnt_o), .busy_o(busy_o)
    );

    // Memory side: random acceptance and responses, write capture just after the negedge.
    initial begin
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i   = 1'b0;
        forever begin
            @(negedge clk);
            mem_cmd_yumi_i = mem_cmd_v_o && !hold_yumi && ($urandom_range(0, 3) != 0);
            mem_resp_v_i   = (outstanding > 0) && ($urandom_range(0, 1) == 1);
            if (mem_resp_v_i) outstanding--;
            #1;
            if (mem_cmd_v_o && mem_cmd_yumi_i &&
                !(rx_axis_tvalid_i && rx_axis_tlast_i && rx_axis_tuser_i && rx_axis_tready_o)) begin
                got_q.push_back({mem_cmd_addr_o, mem_cmd_data_o, mem_cmd_size_o});
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("posted_cnt", 128'(posted_cnt_o), 128'(posted_m.size()));
        check("filled_cnt", 128'(filled_cnt_o), 128'(filled_m));
    endtask

    task automatic check_writes();
        check("wr_count", 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("wr_entry", 128'(got_q[i]), 128'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [AW-1:0] a);
        cmd_v_i   = 1'b1;
        cmd_i     = c;
        cmd_arg_i = a;
        @(posedge clk); #1;
        cmd_v_i   = 1'b0;
    endtask

    task automatic do_post(input logic [AW-1:0] a);
        send_cmd(2'b01, a);
        if (posted_m.size() + filled_m < NB) posted_m.push_back(a);
    endtask

    task automatic do_ack();
        send_cmd(2'b10, '0);
        if (filled_m > 0) filled_m--;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {8'h80, $urandom()};
        a[2:0] = 3'b000;
        return a;
    endfunction

    task automatic set_beat(input logic [AXW-1:0] d, input int bytes, input bit last, input bit user);
        logic [15:0] k;
        k = (16'd1 << bytes) - 16'd1;
        rx_axis_tdata_i  = d;
        rx_axis_tkeep_i  = k[7:0];
        rx_axis_tlast_i  = last;
        rx_axis_tuser_i  = user;
        rx_axis_tvalid_i = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); #2;
            if (rx_axis_tready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        rx_axis_tvalid_i = 1'b0;
        if (!ok) check("beat_accept_timeout", 128'(ok), 128'(1));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #2;
            if (!busy_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        check("idle_reached", 128'(ok), 128'(1));
    endtask

    // Reference: payload beats land at base+8+8*i until the frame is refused; a completed frame
    // adds its byte total at base and consumes the oldest posted buffer.
    task automatic run_frame(input int nb, input int last_bytes, input bit bad, input bit stall);
        logic [AXW-1:0] d [16];
        int by [16];
        logic [AW-1:0] base;
        int cnt;
        bit refused;
        for (int i = 0; i < nb; i++) begin
            d[i]  = {$urandom(), $urandom()};
            by[i] = (i == nb - 1) ? last_bytes : 8;
        end
        base = '0;
        if (posted_m.size() != 0) begin
            base    = posted_m[0];
            cnt     = 0;
            refused = 1'b0;
            for (int i = 0; i < nb; i++) begin
                if ((i == nb - 1 && bad) || (cnt + by[i] > MAXB)) begin refused = 1'b1; break; end
                exp_q.push_back({base + AW'(8 + 8 * i), d[i], 3'd3});
                cnt += by[i];
            end
            if (!refused) begin
                exp_q.push_back({base, AXW'(cnt), 3'd3});
                void'(posted_m.pop_front());
                filled_m++;
            end
        end
        for (int i = 0; i < nb; i++) begin
            set_beat(d[i], by[i], i == nb - 1, bad && (i == nb - 1));
            if (stall && i == 0) begin
                hold_yumi = 1'b1;
                @(posedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #2;
                    check("stall_tready", 128'(rx_axis_tready_o), 128'(0));
                    check("stall_v", 128'(mem_cmd_v_o), 128'(1));
                    check("stall_addr", 128'(mem_cmd_addr_o), 128'(base + AW'(8)));
                    check("stall_data", 128'(mem_cmd_data_o), 128'(d[0]));
                end
                hold_yumi = 1'b0;
            end
            wait_accept();
        end
        wait_idle();
        check_writes();
        check_counters();
    endtask

    initial begin
        reset_i          = 1'b1;
        cmd_v_i          = 1'b0;
        cmd_i            = '0;
        cmd_arg_i        = '0;
        rx_axis_tdata_i  = '0;
        rx_axis_tkeep_i  = '0;
        rx_axis_tvalid_i = 1'b0;
        rx_axis_tlast_i  = 1'b0;
        rx_axis_tuser_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk); #2;
        check("rst_tready", 128'(rx_axis_tready_o), 128'(0));
        check("rst_mem_v", 128'(mem_cmd_v_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_filled", 128'(filled_cnt_o), 128'(0));
        check("rst_posted", 128'(posted_cnt_o), 128'(0));
        @(posedge clk); #1;

        // 20-byte frame into a single buffer
        do_post(40'h00_8000_0000);
        check_counters();
        run_frame(3, 4, 1'b0, 1'b0);
        do_ack();
        check_counters();

        // Fill the ring, overflow POST ignored, drain, then wrap
        for (int i = 0; i < 5; i++) do_post(rand_addr());
        check_counters();
        for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 4), $urandom_range(1, 8), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_ack();
        check_counters();
        do_post(rand_addr());
        run_frame(2, 8, 1'b0, 1'b0);

        // No posted buffer: dropped without writes
        run_frame(2, 8, 1'b0, 1'b0);
        do_ack();

        // Bad frame, then the same buffer reused
        do_post(rand_addr());
        run_frame(3, 5, 1'b1, 1'b0);
        run_frame(2, 3, 1'b0, 1'b0);

        // Oversize frame: prefix written, buffer kept
        do_post(rand_addr());
        run_frame(6, 8, 1'b0, 1'b0);
        run_frame(3, 8, 1'b0, 1'b0);

        // Memory back-pressure mid-frame
        do_post(rand_addr());
        run_frame(3, 8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) do_ack();
        check_counters();

        // Randomized mix of posts, acks and frames
        for (int it = 0; it < 30; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 3) begin
                do_post(rand_addr());
                check_counters();
            end else if (r < 5) begin
                do_ack();
                check_counters();
            end else begin
                run_frame($urandom_range(1, 6), $urandom_range(1, 8), $urandom_range(0, 7) == 0, 1'b0);
            end
        end

        check("max_outstanding_ok", 128'(max_out <= MAXC), 128'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_ring_dma.md
Name: eth_rx_ring_dma

Overview:
Multi-buffer successor to the single-buffer Ethernet RX DMA writer. Accepts frames on an AXIS RX stream and writes each one as uncached writes into the next software-posted buffer of a ring of `num_bufs_p` descriptors. Each buffer holds the payload starting at base+8 and the frame byte length at base+0. Sits between the Ethernet MAC RX FIFO and the I/O command network of the BP tile; software posts and acknowledges buffers through a small command port.

Parameters:
- axis_data_width_p, 64, AXIS beat width in bits (power of 2, 32..512).
- num_bufs_p, 4, ring depth (power of 2, 1..16).
- addr_width_p, 40, physical address width.
- len_width_p, 16, width of the frame length counter.
- max_frame_bytes_p, 2048, largest frame accepted; longer frames are dropped.
- max_credits_p, 256, maximum outstanding memory writes.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- cmd_v_i  in  1  software command valid
- cmd_i  in  2  command: 01 = POST buffer, 10 = ACK oldest filled buffer
- cmd_arg_i  in  addr_width_p  buffer base address for POST; must be 8-byte aligned
- rx_axis_tdata_i  in  axis_data_width_p  beat data
- rx_axis_tkeep_i  in  axis_data_width_p/8  byte enables, contiguous from bit 0
- rx_axis_tvalid_i  in  1  beat valid
- rx_axis_tready_o  out  1  beat accept
- rx_axis_tlast_i  in  1  last beat of frame
- rx_axis_tuser_i  in  1  bad-frame flag, meaningful with tlast
- mem_cmd_v_o  out  1  write request valid
- mem_cmd_addr_o  out  addr_width_p  write address
- mem_cmd_data_o  out  axis_data_width_p  write data; length word zero-extended
- mem_cmd_size_o  out  3  log2 of write size in bytes
- mem_cmd_yumi_i  in  1  write accepted
- mem_resp_v_i  in  1  one write response returned
- filled_cnt_o  out  $clog2(num_bufs_p+1)  filled, unacknowledged buffers
- posted_cnt_o  out  $clog2(num_bufs_p+1)  posted, empty buffers
- busy_o  out  1  frame in progress

Behaviour:
- Reset: all outputs 0. Ring pointers, all counters and credits cleared. Frame FSM goes to IDLE. Posted addresses become don't-care. Reset mid-frame abandons the frame with no length write.
- Ring: base array [num_bufs_p], three pointers (post, fill, ack), each wrapping mod num_bufs_p.
  - POST while posted+filled < num_bufs_p: stores cmd_arg_i at post ptr, post ptr+1.
  - POST while full: ignored.
  - ACK while filled_cnt > 0: ack ptr+1, filled_cnt-1. ACK with nothing filled: ignored.
  - POST and ACK cannot coincide (single cmd port). A fill completion and a POST/ACK in the same cycle are both applied.
- Frame FSM:
  - IDLE: on tvalid, go to PAYLOAD if posted_cnt>0, else DROP. Clear byte count; set offset = base[fill]+8.
  - PAYLOAD:
    - mem_cmd_v_o = tvalid; addr = offset; size = log2(axis_data_width_p/8); data = tdata.
    - rx_axis_tready_o = mem_cmd_yumi_i (combinational).
    - On beat sent: count += popcount(tkeep); offset += axis_data_width_p/8.
    - tvalid & tlast & tuser: beat not sent (v_o still asserted; yumi ignored, tready forced 1); frame discarded, go to IDLE; buffer stays posted.
    - count+popcount > max_frame_bytes_p: beat not sent, go to DROP.
    - Beat sent with tlast: go to LEN.
  - DROP: tready=1, no writes; on tvalid&tlast go to IDLE. Buffer is not consumed.
  - LEN: v_o=1, addr=base[fill], size=3 (8 bytes), data=count. On yumi go to SYNC.
  - SYNC: wait until credits==0, then fill ptr+1, posted-1, filled+1, go to IDLE.
- Credits: +1 per sent write (payload or length), -1 per mem_resp_v_i; simultaneous events net to 0. Increment is blocked (v_o held low) when credits==max_credits_p.
- busy_o = FSM not IDLE.

Optional Feature:
- ETH_RX_DROP_STATS_EN defined: adds outputs drop_nobuf_o, drop_bad_o, drop_long_o (16 bits each). Each is a saturating counter of frames dropped for no buffer, tuser, or oversize respectively, incremented once per frame at the drop decision; cleared on reset.
- Undefined: these ports do not exist and no counters are built.

Test Plan:
- POST 0x8000_0000, 20-byte frame of 3 beats (last tkeep=0x0F) -> writes at 0x8000_0008/10/18, then length 20 at 0x8000_0000; filled_cnt_o=1 once 4 responses return.
- POST 4 buffers, 5th POST -> ignored, posted_cnt_o=4; 4 frames fill buffers in post order; ACK ×4 -> filled_cnt_o=0, pointers wrap correctly on the next frame.
- No buffer posted, 2-beat frame -> tready=1 both beats, zero writes, counters unchanged (drop_nobuf_o=1 if enabled).
- Frame with tuser on tlast -> no length write, posted_cnt_o unchanged; next frame reuses the same buffer at base+8.
- max_frame_bytes_p=16, 3 full 64-bit beats -> 2 writes issued, 3rd beat dropped, no length write, buffer still posted.
- mem_cmd_yumi_i held low 5 cycles mid-frame -> tready low for those cycles; data and addresses are stable and no beat is lost.
